// File: rtl/clarvi_soc_pio_hex_display.sv
// clarvi_soc_pio_hex_display: Avalon-MM slave driving NUM_DIGITS active-low 7-segment digits from hex nibbles.
// Blink hardware (BLINK, BLINK_DIV, blink counter, STATUS phase) is built only when HEXDISP_BLINK_EN is defined.
module clarvi_soc_pio_hex_display #(
    parameter int NUM_DIGITS = 6,
    parameter int DIV_W = 24,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(12_499_999)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [2:0]                address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    output logic [4*NUM_DIGITS-1:0]   out_port,
    output logic [7*NUM_DIGITS-1:0]   hex_n
);
    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic                    wr;
    logic [4*NUM_DIGITS-1:0] data_q, data_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d, blink_m;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic                    phase;
    logic                    unused_bits;
    assign wr = chipselect & ~write_n;
    assign unused_bits = ^writedata;
    always_comb begin
        data_d = (wr && address == 3'd0) ? writedata[4*NUM_DIGITS-1:0] : data_q;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (wr && address == 3'd4 && writedata[11:8] == 4'(i)) data_d[4*i+:4] = writedata[3:0];
        blank_d = (wr && address == 3'd1) ? writedata[NUM_DIGITS-1:0] : blank_q;
        hex_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++)
            hex_d[7*i+:7] = (blank_q[i] | (blink_m[i] & phase)) ? 7'h7F : SEG[data_q[4*i+:4]];
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            blank_q <= '0;
            hex_q   <= '1;
        end else begin
            data_q  <= data_d;
            blank_q <= blank_d;
            hex_q   <= hex_d;
        end
    end
`ifdef HEXDISP_BLINK_EN
    logic [NUM_DIGITS-1:0] blink_q, blink_d;
    logic [DIV_W-1:0]      div_q, div_d, cnt_q, cnt_d;
    logic                  phase_q, phase_d, wr_div;
    assign wr_div = wr && address == 3'd3;
    // A BLINK_DIV write restarts the half-period from phase 0, overriding any reload/toggle.
    always_comb begin
        blink_d = (wr && address == 3'd2) ? writedata[NUM_DIGITS-1:0] : blink_q;
        div_d   = wr_div ? writedata[DIV_W-1:0] : div_q;
        cnt_d   = wr_div ? writedata[DIV_W-1:0] : (cnt_q == '0) ? div_q : cnt_q - DIV_W'(1);
        phase_d = wr_div ? 1'b0 : phase_q ^ (cnt_q == '0);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_q <= '0;
            div_q   <= DEFAULT_DIV;
            cnt_q   <= DEFAULT_DIV;
            phase_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end
    assign blink_m = blink_q;
    assign phase   = phase_q;
`else
    assign blink_m = '0;
    assign phase   = 1'b0;
`endif
    always_comb begin
        readdata = '0;
        case (address)
            3'd0: readdata = 32'(data_q);
            3'd1: readdata = 32'(blank_q);
`ifdef HEXDISP_BLINK_EN
            3'd2: readdata = 32'(blink_q);
            3'd3: readdata = 32'(div_q);
            3'd5: readdata = {31'b0, phase_q};
`endif
            default: readdata = '0;
        endcase
    end
    assign out_port = data_q;
    assign hex_n    = hex_q;
endmodule

// File: tb/tb_clarvi_soc_pio_hex_display.sv
// tb_clarvi_soc_pio_hex_display: directed and random checks of the hex display slave against a digit-level model.
// Blink expectations are enabled when HEXDISP_BLINK_EN is defined, matching the DUT build.
module tb_clarvi_soc_pio_hex_display;
    localparam int N = 6;
    localparam int DW = 24;
    localparam logic [DW-1:0] DEF = 24'd12_499_999;
    localparam logic [6:0] SEG_T [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic clk = 1'b0;
    logic reset_n;
    logic [2:0] address;
    logic chipselect, write_n;
    logic [31:0] writedata, readdata;
    logic [4*N-1:0] out_port;
    logic [7*N-1:0] hex_n;
    int errors = 0;
    int checks = 0;
    logic [3:0] dig [N];
    logic [N-1:0] m_blank, m_blink;
    longint m_div, m_n;
    logic [7*N-1:0] exp_hex;

    clarvi_soc_pio_hex_display #(.NUM_DIGITS(N), .DIV_W(DW), .DEFAULT_DIV(DEF)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .hex_n(hex_n)
    );
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Phase is a square wave of half-period div+1 edges, restarted by reset or a BLINK_DIV write.
    function automatic logic m_phase();
        return ((m_n / (m_div + 1)) % 2) == 1;
    endfunction
    function automatic logic [4*N-1:0] m_data();
        logic [4*N-1:0] r;
        for (int i = 0; i < N; i++) r[4*i+:4] = dig[i];
        return r;
    endfunction
    function automatic logic [7*N-1:0] m_hex();
        logic [7*N-1:0] r;
        for (int i = 0; i < N; i++)
            r[7*i+:7] = (m_blank[i] | (m_blink[i] & m_phase())) ? 7'h7F : SEG_T[dig[i]];
        return r;
    endfunction
    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return 32'(m_data());
            3'd1: return 32'(m_blank);
`ifdef HEXDISP_BLINK_EN
            3'd2: return 32'(m_blink);
            3'd3: return 32'(m_div);
            3'd5: return 32'(m_phase());
`endif
            default: return 32'd0;
        endcase
    endfunction
    task automatic m_reset();
        for (int i = 0; i < N; i++) dig[i] = 4'd0;
        m_blank = '0;
        m_blink = '0;
        m_div = longint'(DEF);
        m_n = 0;
        exp_hex = '1;
    endtask
    task automatic m_apply(input logic w, input logic [2:0] a, input logic [31:0] wd);
        logic dw = 1'b0;
        if (w) begin
            case (a)
                3'd0: for (int i = 0; i < N; i++) dig[i] = wd[4*i+:4];
                3'd1: m_blank = wd[N-1:0];
`ifdef HEXDISP_BLINK_EN
                3'd2: m_blink = wd[N-1:0];
                3'd3: begin m_div = longint'(wd[DW-1:0]); dw = 1'b1; end
`endif
                3'd4: if (int'(wd[11:8]) < N) dig[wd[11:8]] = wd[3:0];
                default: ;
            endcase
        end
        if (dw) m_n = 0; else m_n++;
    endtask

    task automatic step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
        chipselect = cs;
        write_n = wn;
        address = a;
        writedata = wd;
        @(posedge clk);
        exp_hex = m_hex();
        m_apply(cs & ~wn, a, wd);
        #1;
        check("out_port", 64'(out_port), 64'(m_data()));
        check("hex_n", 64'(hex_n), 64'(exp_hex));
    endtask
    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        step(1'b1, 1'b0, a, wd);
    endtask
    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b1, 3'd0, $urandom);
    endtask
    task automatic readchk(input logic [2:0] a);
        chipselect = 1'b1;
        write_n = 1'b1;
        address = a;
        #1;
        check($sformatf("readdata@%0d", a), 64'(readdata), 64'(m_read(a)));
    endtask

    initial begin
        reset_n = 1'b0;
        chipselect = 1'b0;
        write_n = 1'b1;
        address = 3'd0;
        writedata = '0;
        m_reset();
        #12;
        check("rst_hex_dark", 64'(hex_n), {22'b0, {42{1'b1}}});
        check("rst_out_port", 64'(out_port), 64'd0);
        reset_n = 1'b1;
        idle(1);
        check("idle_hex_zero", 64'(hex_n), {22'b0, {6{7'h40}}});
        readchk(3'd0);
        readchk(3'd3);
        wr(3'd0, 32'h00FEDCBA);
        check("data_same_edge", 64'(out_port), 64'h00FEDCBA);
        idle(1);
        check("hex_fedcba", 64'(hex_n), {22'b0, 7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08});
        wr(3'd4, 32'h0000_0207);
        check("digit_wr", 64'(out_port), 64'h00FED7BA);
        wr(3'd4, 32'h0000_0905);
        check("digit_wr_oob", 64'(out_port), 64'h00FED7BA);
        readchk(3'd4);
        wr(3'd3, 32'd1);
        wr(3'd1, 32'h1);
        wr(3'd2, 32'h1);
        for (int i = 0; i < 6; i++) begin idle(1); readchk(3'd5); end
        wr(3'd1, 32'h0);
        for (int i = 0; i < 6; i++) begin idle(1); readchk(3'd5); end
        wr(3'd3, 32'hFF00_0003);
        wr(3'd2, 32'h1);
        wr(3'd0, 32'h0);
        readchk(3'd3);
        for (int i = 0; i < 12; i++) begin idle(1); readchk(3'd5); end
        for (int i = 0; i < 2000; i++) begin
            logic [2:0] a;
            logic [31:0] wd;
            a = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 3'd3) wd[DW-1:0] = DW'($urandom_range(0, 4));
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, wd);
            readchk(3'($urandom_range(0, 7)));
        end
        wr(3'd3, 32'd2);
        wr(3'd1, 32'h0);
        wr(3'd2, 32'h3F);
        for (int k = 0; k < 8 && !m_phase(); k++) idle(1);
        readchk(3'd5);
        reset_n = 1'b0;
        m_reset();
        #1;
        check("async_rst_hex", 64'(hex_n), {22'b0, {42{1'b1}}});
        check("async_rst_data", 64'(out_port), 64'd0);
        readchk(3'd1);
        readchk(3'd2);
        readchk(3'd3);
        readchk(3'd5);
        @(negedge clk);
        reset_n = 1'b1;
        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
